pp_accumulator: RTL
===================

PP_ACCUMULATOR -- requirements
Module: pp_accumulator

Interface
REQ-001 Parameter N_PP, default 9, meaning the number of Booth radix-4 partial products per operation.
REQ-002 Parameter PP_W, default 18, meaning the width of each signed partial product.
REQ-003 Parameter P_W, default 32, meaning the product width.
REQ-004 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  upstream partial-product set valid.
REQ-007 in_ready  output  1  block can accept a set.
REQ-008 pp0..pp8  input  PP_W each  signed partial products from the Booth generator; pp[i] has weight 4^i.
REQ-009 neg  input  8  two's-complement completion bits; neg[i] has weight 4^i, i = 0..7.
REQ-010 out_valid  output  1  product valid.
REQ-011 out_ready  input  1  downstream accepts product.
REQ-012 product  output  P_W  signed product.
REQ-013 busy  output  1  high in the ACCUM or DONE state.

Function
REQ-014 The FSM SHALL have the states IDLE, ACCUM and DONE.
REQ-015 in_ready SHALL equal (state == IDLE).
REQ-016 On an edge with in_valid=1 and in_ready=1, the block SHALL register pp0..pp8 and neg, clear acc to 0, set idx to 0 and enter ACCUM.
REQ-017 On each ACCUM edge, acc SHALL become acc + (sign_extend(pp[idx]) << 2*idx) + (idx<8 ? neg[idx] << 2*idx : 0), computed modulo 2^P_W, and idx SHALL increment.
REQ-018 On the ACCUM edge where idx == N_PP-1, the FSM SHALL enter DONE with out_valid=1.
REQ-019 out_valid SHALL therefore first be high N_PP edges (9) after the acceptance edge, giving a throughput of one result per 11 cycles minimum.
REQ-020 In DONE, product SHALL equal acc, and product and out_valid SHALL be held stable until out_ready=1.
REQ-021 On a DONE edge with out_ready=1, the FSM SHALL return to IDLE and out_valid SHALL fall.
REQ-022 The FSM SHALL NOT accept a new set in the same cycle as an output handshake.
REQ-023 in_valid SHALL be ignored while busy=1, and the registered inputs SHALL NOT change.
REQ-024 Changes on pp*/neg after acceptance SHALL NOT affect the result.
REQ-025 out_ready in IDLE or ACCUM SHALL have no effect.
REQ-026 The result SHALL equal MD*MR (signed 16x16) for any set produced by the team's Booth generator from MD and MR.
REQ-027 No overflow indication SHALL be provided; truncation to P_W is exact for this range.

Reset
REQ-028 When rst_n=0 at a clock edge: state=IDLE, idx=0, acc=0, out_valid=0, product=0, busy=0, in_ready=1 after the edge.
REQ-029 Reset SHALL take priority over every other event, including a reset asserted in the middle of ACCUM or in DONE; any partial result SHALL be discarded.
REQ-030 The first acceptance SHALL be possible on the first edge with rst_n=1.

Structure
REQ-031 A shared package pp_pkg SHALL hold N_PP, PP_W, P_W, the FSM state encoding (IDLE=2'b00, ACCUM=2'b01, DONE=2'b10) and the index width (4 bits).
REQ-032 The block SHALL have one combinational sub-module, pp_term_align, that sign-extends and shifts the selected pp and adds the neg bit, producing the P_W-bit term.
REQ-033 The accumulator adder and the term mux SHALL reside in pp_accumulator.

Verification
REQ-034 Drive the Booth generator with MD=16'h0003, MR=16'h0005 -> product=32'h0000000F, out_valid rising 9 edges after acceptance.
REQ-035 Drive MD=16'h7FFF, MR=16'h7FFF -> product=32'h3FFF0001; drive MD=16'h8000, MR=16'h8000 -> product=32'h40000000.
REQ-036 Drive MD=16'hFFFF, MR=16'h0001 -> product=32'hFFFFFFFF; then hold out_ready=0 for 5 cycles -> product and out_valid stay stable, in_ready=0 throughout.
REQ-037 Pulse in_valid with different data during ACCUM -> the data is ignored and the first result is unchanged; after the output handshake, in_ready=1 on the next cycle.
REQ-038 Drive rst_n=0 for one edge at idx=4 -> state=IDLE, out_valid=0, product=0; a following MD=16'h0002, MR=16'hFFFD operation -> product=32'hFFFFFFFA.

Source files
------------

// File: rtl/pp_pkg.sv
// Shared constants and FSM encoding for the partial-product accumulator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pp_pkg;

    localparam int N_PP  = 9;   // Booth radix-4 partial products per operation
    localparam int PP_W  = 18;  // width of one signed partial product
    localparam int P_W   = 32;  // product width
    localparam int IDX_W = 4;   // width of the partial-product index

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/pp_term_align.sv
// Aligns one partial product: sign-extends pp, adds its neg bit, shifts by 2*idx.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: pp (selected partial product), neg_bit (completion bit for that slot),
//        idx (slot index, weight 4^idx), term (P_W-bit aligned addend).
module pp_term_align import pp_pkg::*; #(
    parameter int PP_W  = pp_pkg::PP_W,
    parameter int P_W   = pp_pkg::P_W,
    parameter int IDX_W = pp_pkg::IDX_W
) (
    input  logic signed [PP_W-1:0]  pp,
    input  logic                    neg_bit,
    input  logic        [IDX_W-1:0] idx,
    output logic        [P_W-1:0]   term
);

    logic [P_W-1:0] pp_ext;
    logic [P_W-1:0] neg_ext;
    logic [IDX_W:0] shamt;

    assign pp_ext  = {{(P_W-PP_W){pp[PP_W-1]}}, pp};
    assign neg_ext = {{(P_W-1){1'b0}}, neg_bit};
    assign shamt   = {idx, 1'b0};

    // Adding neg before the shift is equivalent to adding both at weight 4^idx.
    assign term = (pp_ext + neg_ext) << shamt;

endmodule

// File: rtl/pp_accumulator.sv
// Sums Booth radix-4 partial products (plus completion bits) into a signed product.
// Latency: out_valid rises N_PP edges after the accepting edge; one result per >= 11 cycles.
// Backpressure: in_ready only in IDLE; product/out_valid held in DONE until out_ready.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with pp0..pp8 and neg[7:0];
//        out_valid/out_ready with product; busy (high in ACCUM or DONE).
module pp_accumulator import pp_pkg::*; #(
    parameter int N_PP = pp_pkg::N_PP,
    parameter int PP_W = pp_pkg::PP_W,
    parameter int P_W  = pp_pkg::P_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [PP_W-1:0] pp0,
    input  logic signed [PP_W-1:0] pp1,
    input  logic signed [PP_W-1:0] pp2,
    input  logic signed [PP_W-1:0] pp3,
    input  logic signed [PP_W-1:0] pp4,
    input  logic signed [PP_W-1:0] pp5,
    input  logic signed [PP_W-1:0] pp6,
    input  logic signed [PP_W-1:0] pp7,
    input  logic signed [PP_W-1:0] pp8,
    input  logic        [7:0]      neg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic        [P_W-1:0]  product,
    output logic                   busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PP - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [P_W-1:0]          acc;
    logic signed [PP_W-1:0]  pp_r [9];
    logic [7:0]              neg_r;
    logic signed [PP_W-1:0]  pp_sel;
    logic                    neg_sel;
    logic [P_W-1:0]          term;
    logic                    accept;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                busy = 1'b1;
                if (idx == LAST_IDX) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Returning to IDLE here (not straight to ACCUM) keeps an output
                // handshake and a new acceptance in separate cycles.
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept = (state == ST_IDLE) && in_valid;

    // ---------------- term mux ----------------
    always_comb begin
        pp_sel = '0;
        case (idx)
            4'd0: pp_sel = pp_r[0];
            4'd1: pp_sel = pp_r[1];
            4'd2: pp_sel = pp_r[2];
            4'd3: pp_sel = pp_r[3];
            4'd4: pp_sel = pp_r[4];
            4'd5: pp_sel = pp_r[5];
            4'd6: pp_sel = pp_r[6];
            4'd7: pp_sel = pp_r[7];
            4'd8: pp_sel = pp_r[8];
            default: pp_sel = '0;
        endcase
    end

    // The top partial product has no completion bit.
    assign neg_sel = (idx < 4'd8) ? neg_r[idx[2:0]] : 1'b0;

    pp_term_align #(
        .PP_W  (PP_W),
        .P_W   (P_W),
        .IDX_W (IDX_W)
    ) u_align (
        .pp      (pp_sel),
        .neg_bit (neg_sel),
        .idx     (idx),
        .term    (term)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            acc   <= '0;
            neg_r <= '0;
            for (int i = 0; i < 9; i++) pp_r[i] <= '0;
        end else if (accept) begin
            idx     <= '0;
            acc     <= '0;
            neg_r   <= neg;
            pp_r[0] <= pp0;
            pp_r[1] <= pp1;
            pp_r[2] <= pp2;
            pp_r[3] <= pp3;
            pp_r[4] <= pp4;
            pp_r[5] <= pp5;
            pp_r[6] <= pp6;
            pp_r[7] <= pp7;
            pp_r[8] <= pp8;
        end else if (state == ST_ACCUM) begin
            acc <= acc + term;   // wraps modulo 2^P_W
            idx <= idx + 4'd1;
        end
    end

    assign product = acc;

endmodule
